reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- In-order retirement stage directly downstream of the reservation station and the load/store buffer.
- Allocates one entry per issued instruction, in program order, and gives the instruction unit the entry's ROB index.
- Captures results from the RS and LSB broadcast buses and retires entries in order from the head to the register file and LSB.
- Detects branch mispredictions at commit and flushes the whole machine.

Parameters:
- ROB_WIDTH, 4, index width; DEPTH = 2**ROB_WIDTH entries.

Ports:
- clockIn, input, 1, clock; all state updates on the rising edge.
- resetIn, input, 1, synchronous reset, active-low: 0 at a rising edge resets the block.
- issueValid, input, 1, allocate an entry this cycle.
- issueType, input, 2, 00 = REG, 01 = STORE, 10 = BRANCH; 11 reserved, treated as REG.
- issueDest, input, 5, destination register (REG only).
- issuePredTaken, input, 1, predicted direction (BRANCH only).
- issueAltPc, input, 32, PC to restart at if the prediction is wrong.
- issueRobIndex, output, ROB_WIDTH, tail index given to the current issue (combinational).
- full, output, 1, issue must stall.
- rsUpdate / rsRobIndex / rsVal, input, 1 / ROB_WIDTH / 32, RS result bus.
- lsbUpdate / lsbRobIndex / lsbVal, input, 1 / ROB_WIDTH / 32, LSB result bus.
- query1Index / query2Index, input, ROB_WIDTH, operand lookup from the instruction unit.
- query1Ready / query2Ready, output, 1, the queried value is available.
- query1Val / query2Val, output, 32, the queried value.
- commitValid, output, 1, register write-back pulse.
- commitDest, output, 5, destination of the write-back.
- commitVal, output, 32, value of the write-back.
- commitRobIndex, output, ROB_WIDTH, index of the retired entry (REG and STORE commits).
- commitStore, output, 1, STORE at head retired; LSB may perform the write.
- flushOut, output, 1, misprediction flush pulse.
- flushPc, output, 32, restart PC for the flush.

Behaviour:
- State: circular buffer with head, tail and count (ROB_WIDTH+1 bits). Per entry: valid, ready, type, dest, predTaken, altPc, value.
- Reset (resetIn = 0):
  - head = tail = count = 0; all valid and ready bits cleared.
  - All registered outputs = 0: commitValid, commitStore, flushOut, commitDest, commitVal, commitRobIndex, flushPc.
  - Reset overrides every other input, including mid-flush or mid-commit.
- Issue:
  - When issueValid = 1 and no flush is happening this cycle, entry[tail] is written with valid = 1 and ready = 0.
  - Then tail = tail + 1, which wraps modulo DEPTH.
  - issueRobIndex always equals tail.
- full = (count >= DEPTH-2). The two spare slots absorb the instruction unit's registered-issue slack.
- Issuing while count = DEPTH is illegal; the bench asserts on it.
- Result capture:
  - rsUpdate writes value = rsVal and ready = 1 into entry[rsRobIndex]. The LSB bus does the same with its own index and value.
  - Both buses targeting the same index in one cycle: LSB wins.
  - An update to an invalid entry is ignored.
  - For STORE entries, the lsbUpdate that marks the entry ready means "address and data resolved".
- Commit (evaluated every cycle): if entry[head] is valid and ready, it retires. Outputs are registered and pulse for exactly one cycle.
  - REG: commitValid = 1, commitDest = dest, commitVal = value, commitRobIndex = head.
  - STORE: commitStore = 1, commitRobIndex = head.
  - BRANCH, value[0] == predTaken: retires with no output pulse.
  - BRANCH, value[0] != predTaken: flushOut = 1 and flushPc = altPc. In the same edge, all valid bits are cleared and head = tail = count = 0. issueValid in that cycle is ignored.
- Retiring entries: valid is cleared and head = head + 1 (wraps), except on a flush, where head = 0.
- At most one commit per cycle.
- Count update:
  - Issue and commit in the same cycle: count unchanged.
  - Issue only: count + 1.
  - Commit only: count - 1.
- Latency: a result arriving in cycle t for the head entry produces its commit pulse in cycle t+2.
- Query ports (combinational), for each of the two lookups:
  - Ready = 1 if entry[idx] is valid and ready, or if a result bus carries idx in this same cycle (bypass).
  - Bypass priority: LSB bus, then RS bus, then stored value.
  - Otherwise ready = 0 and val = 0.

Test Plan:
- Reset then idle: resetIn = 0 for 2 cycles, then 1 → full = 0, issueRobIndex = 0, all commit and flush outputs 0 for 10 cycles.
- In-order retire with out-of-order results:
  - Issue REG x5 (index 0) and REG x6 (index 1).
  - rsUpdate index 1 = 0x22 first, then index 0 = 0x11 one cycle later.
  - Expect commit of x5 = 0x11, then x6 = 0x22 on consecutive cycles. Nothing commits before index 0 is ready.
- Full and wrap:
  - Issue 14 REG entries with no results → full = 1.
  - Resolve and retire 4, issue 4 more → issueRobIndex goes 14, 15, 0, 1. Commits occur in index order across the wrap.
- Mispredict flush:
  - Issue BRANCH predTaken = 1, altPc = 0x1000, followed by REG x7.
  - rsUpdate on the branch entry with value 0.
  - Expect flushOut = 1 and flushPc = 0x1000 for one cycle; after that count = 0, issueRobIndex = 0, and x7 never commits.
- Store and collisions:
  - STORE at index 0: lsbUpdate → commitStore = 1 with commitRobIndex = 0 two cycles later.
  - RS and LSB buses to index 2 in the same cycle → stored value is the LSB value.
- Query bypass: query1Index = 3 in the same cycle as rsUpdate for index 3 with 0xABCD → query1Ready = 1 and query1Val = 0xABCD combinationally.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus bundle: issue, result buses, operand queries,
// commit and flush. master = issue/execute side, slave = the ROB.
interface reorder_buffer_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 issueValid;
    logic [1:0]           issueType;
    logic [4:0]           issueDest;
    logic                 issuePredTaken;
    logic [31:0]          issueAltPc;
    logic [ROB_WIDTH-1:0] issueRobIndex;
    logic                 full;

    logic                 rsUpdate;
    logic [ROB_WIDTH-1:0] rsRobIndex;
    logic [31:0]          rsVal;
    logic                 lsbUpdate;
    logic [ROB_WIDTH-1:0] lsbRobIndex;
    logic [31:0]          lsbVal;

    logic [ROB_WIDTH-1:0] query1Index;
    logic [ROB_WIDTH-1:0] query2Index;
    logic                 query1Ready;
    logic                 query2Ready;
    logic [31:0]          query1Val;
    logic [31:0]          query2Val;

    logic                 commitValid;
    logic [4:0]           commitDest;
    logic [31:0]          commitVal;
    logic [ROB_WIDTH-1:0] commitRobIndex;
    logic                 commitStore;
    logic                 flushOut;
    logic [31:0]          flushPc;

    modport master (
        output issueValid, issueType, issueDest,
        output issuePredTaken, issueAltPc,
        input  issueRobIndex, full,
        output rsUpdate, rsRobIndex, rsVal,
        output lsbUpdate, lsbRobIndex, lsbVal,
        output query1Index, query2Index,
        input  query1Ready, query2Ready,
        input  query1Val, query2Val,
        input  commitValid, commitDest, commitVal,
        input  commitRobIndex, commitStore,
        input  flushOut, flushPc
    );

    modport slave (
        input  issueValid, issueType, issueDest,
        input  issuePredTaken, issueAltPc,
        output issueRobIndex, full,
        input  rsUpdate, rsRobIndex, rsVal,
        input  lsbUpdate, lsbRobIndex, lsbVal,
        input  query1Index, query2Index,
        output query1Ready, query2Ready,
        output query1Val, query2Val,
        output commitValid, commitDest, commitVal,
        output commitRobIndex, commitStore,
        output flushOut, flushPc
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer. Ports: clockIn, resetIn (sync, active-low),
// bus (slave): issue/alloc, RS+LSB result capture, queries, commit, flush.
module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input logic             clockIn,
    input logic             resetIn,
    reorder_buffer_if.slave bus
);
    localparam int DEPTH = 2 ** ROB_WIDTH;

    typedef enum logic [1:0] {
        TypeReg    = 2'b00,
        TypeStore  = 2'b01,
        TypeBranch = 2'b10,
        TypeRsvd   = 2'b11
    } entryType_e;

    logic              entryValid [DEPTH];
    logic              entryReady [DEPTH];
    entryType_e        entryType  [DEPTH];
    logic [4:0]        entryDest  [DEPTH];
    logic              entryPred  [DEPTH];
    logic [31:0]       entryAltPc [DEPTH];
    logic [31:0]       entryValue [DEPTH];

    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;

    logic headFires;
    logic headIsBranch;
    logic headIsStore;
    logic mispredict;
    logic branchOk;
    logic doIssue;

    assign headFires    = entryValid[head] && entryReady[head];
    assign headIsBranch = entryType[head] == TypeBranch;
    assign headIsStore  = entryType[head] == TypeStore;
    assign mispredict   = headFires && headIsBranch
                       && (entryValue[head][0] != entryPred[head]);
    assign branchOk     = headFires && headIsBranch && !mispredict;
    // A flush wipes the machine, so a same-cycle issue is dropped.
    assign doIssue      = bus.issueValid && !mispredict;

    assign bus.issueRobIndex = tail;
    assign bus.full = count >= (ROB_WIDTH + 1)'(DEPTH - 2);

    // Operand lookup with result-bus bypass: LSB, then RS, then stored.
    function automatic logic [32:0] lookup(
        input logic [ROB_WIDTH-1:0] idx
    );
        logic [32:0] res;
        res = '0;
        if (bus.lsbUpdate && bus.lsbRobIndex == idx)
            res = {1'b1, bus.lsbVal};
        else if (bus.rsUpdate && bus.rsRobIndex == idx)
            res = {1'b1, bus.rsVal};
        else if (entryValid[idx] && entryReady[idx])
            res = {1'b1, entryValue[idx]};
        return res;
    endfunction

    always_comb begin
        {bus.query1Ready, bus.query1Val} = lookup(bus.query1Index);
        {bus.query2Ready, bus.query2Val} = lookup(bus.query2Index);
    end

    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entryValid[i] <= 1'b0;
                entryReady[i] <= 1'b0;
            end
            bus.commitValid    <= 1'b0;
            bus.commitStore    <= 1'b0;
            bus.flushOut       <= 1'b0;
            bus.commitDest     <= '0;
            bus.commitVal      <= '0;
            bus.commitRobIndex <= '0;
            bus.flushPc        <= '0;
        end else begin
            bus.commitValid <= 1'b0;
            bus.commitStore <= 1'b0;
            bus.flushOut    <= 1'b0;

            // LSB written last so it wins a same-index collision.
            if (bus.rsUpdate && entryValid[bus.rsRobIndex]) begin
                entryValue[bus.rsRobIndex] <= bus.rsVal;
                entryReady[bus.rsRobIndex] <= 1'b1;
            end
            if (bus.lsbUpdate && entryValid[bus.lsbRobIndex]) begin
                entryValue[bus.lsbRobIndex] <= bus.lsbVal;
                entryReady[bus.lsbRobIndex] <= 1'b1;
            end

            if (doIssue) begin
                entryValid[tail] <= 1'b1;
                entryReady[tail] <= 1'b0;
                entryType[tail]  <= entryType_e'(bus.issueType);
                entryDest[tail]  <= bus.issueDest;
                entryPred[tail]  <= bus.issuePredTaken;
                entryAltPc[tail] <= bus.issueAltPc;
                tail <= tail + 1'b1;
            end

            if (headFires) begin
                unique case (1'b1)
                    mispredict: begin
                        bus.flushOut <= 1'b1;
                        bus.flushPc  <= entryAltPc[head];
                    end
                    branchOk: begin
                    end
                    headIsStore: begin
                        bus.commitStore    <= 1'b1;
                        bus.commitRobIndex <= head;
                    end
                    default: begin
                        bus.commitValid    <= 1'b1;
                        bus.commitDest     <= entryDest[head];
                        bus.commitVal      <= entryValue[head];
                        bus.commitRobIndex <= head;
                    end
                endcase
                entryValid[head] <= 1'b0;
                head <= head + 1'b1;
            end

            if (mispredict) begin
                for (int i = 0; i < DEPTH; i++)
                    entryValid[i] <= 1'b0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else if (doIssue && !headFires) begin
                count <= count + 1'b1;
            end else if (!doIssue && headFires) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule
